comp_arbiter: RTL and testbench

COMP_ARBITER -- requirements
Module: comp_arbiter

---
 rtl/comp_arbiter_pkg.sv | 19 +
 rtl/fp_lt_cmp.sv | 35 +++
 rtl/comp_arbiter.sv | 111 +++++++++++
 tb/tb_comp_arbiter.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/comp_arbiter_pkg.sv
// Shared constants and pipeline-entry type for the comp_arbiter threshold compare block.
package comp_arbiter_pkg;

    localparam logic [31:0] FP_ONE      = 32'h3F800000;
    localparam logic [31:0] FP_ZERO     = 32'h00000000;
    localparam logic [31:0] BIN_DEFAULT = 32'h3E800006;
    localparam int          ID_W        = 3;

    typedef struct packed {
        logic            valid;
        logic [ID_W-1:0] id;
        logic [31:0]     data;
    } pipe_entry_t;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/fp_lt_cmp.sv
// Combinational float threshold compare: lt = sign(operand - BIN); Inf/NaN operands never compare low.
module fp_lt_cmp
    import comp_arbiter_pkg::*;
#(
    parameter logic [31:0] BIN = BIN_DEFAULT
) (
    input  logic [31:0] operand,
    output logic        lt
);

    localparam logic        B_NEG = BIN[31];
    localparam logic [30:0] B_MAG = BIN[30:0];

    logic        a_neg;
    logic [30:0] a_mag;
    logic        a_special;

    assign a_neg     = operand[31];
    assign a_mag     = operand[30:0];
    assign a_special = (operand[30:23] == 8'hFF);

    // Sign-magnitude ordering gives the exact sign of the difference; +0 and -0 are equal.
    always_comb begin
        lt = 1'b0;
        if (!a_special) begin
            case ({a_neg, B_NEG})
                2'b00:   lt = (a_mag < B_MAG);
                2'b01:   lt = 1'b0;
                2'b10:   lt = !((a_mag == 31'd0) && (B_MAG == 31'd0));
                default: lt = (a_mag > B_MAG);
            endcase
        end
    end

endmodule

// File: rtl/comp_arbiter.sv
// Round-robin arbiter feeding a shared 2-stage float threshold comparator with one-hot responses.
// Optional statistics counters (hit_cnt, op_cnt) are built when COMP_ARB_STATS_EN is defined.
module comp_arbiter
    import comp_arbiter_pkg::*;
#(
    parameter int          NUM_REQ = 4,
    parameter logic [31:0] BIN     = BIN_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   en,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [NUM_REQ*32-1:0]  req_data,
    output logic [NUM_REQ-1:0]     req_ready,
    output logic [NUM_REQ-1:0]     rsp_valid,
    output logic [31:0]            rsp_data,
    output logic                   busy
`ifdef COMP_ARB_STATS_EN
    ,
    output logic [15:0]            hit_cnt,
    output logic [15:0]            op_cnt
`endif
);

    logic [ID_W-1:0]    last_grant;
    logic [ID_W-1:0]    grant_id;
    logic [ID_W-1:0]    hi_id;
    logic [ID_W-1:0]    lo_id;
    logic               hi_found;
    logic               lo_found;
    logic               grant_any;
    logic [31:0]        grant_data;
    logic               s1_lt;
    logic [NUM_REQ-1:0] rsp_valid_next;
    pipe_entry_t        s1_reg;
    pipe_entry_t        s2_reg;

    // Lowest valid index above the pointer wins; otherwise wrap to the lowest valid index.
    always_comb begin
        hi_found = 1'b0;
        lo_found = 1'b0;
        hi_id    = '0;
        lo_id    = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                lo_found = 1'b1;
                lo_id    = ID_W'(i);
                if (ID_W'(i) > last_grant) begin
                    hi_found = 1'b1;
                    hi_id    = ID_W'(i);
                end
            end
        end
        grant_any = en && lo_found;
        grant_id  = hi_found ? hi_id : lo_id;
    end

    always_comb begin
        req_ready      = '0;
        rsp_valid_next = '0;
        grant_data     = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_ready[i]      = grant_any && (ID_W'(i) == grant_id);
            rsp_valid_next[i] = s2_reg.valid && (ID_W'(i) == s2_reg.id);
            if (ID_W'(i) == grant_id) begin
                grant_data = req_data[32*i +: 32];
            end
        end
    end

    fp_lt_cmp #(.BIN(BIN)) u_cmp (
        .operand (s1_reg.data),
        .lt      (s1_lt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= ID_W'(NUM_REQ - 1);
            s1_reg     <= '0;
            s2_reg     <= '0;
            rsp_valid  <= '0;
            rsp_data   <= FP_ZERO;
        end else begin
            if (grant_any) begin
                last_grant <= grant_id;
            end
            s1_reg    <= '{valid: grant_any, id: grant_id, data: grant_data};
            s2_reg    <= '{valid: s1_reg.valid, id: s1_reg.id, data: (s1_lt ? FP_ONE : FP_ZERO)};
            rsp_valid <= rsp_valid_next;
            rsp_data  <= s2_reg.valid ? s2_reg.data : FP_ZERO;
        end
    end

    assign busy = s1_reg.valid || s2_reg.valid || (|rsp_valid);

`ifdef COMP_ARB_STATS_EN
    // Counters advance on the same edge that presents the response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_cnt <= '0;
            op_cnt  <= '0;
        end else if (s2_reg.valid) begin
            op_cnt <= sat_inc(op_cnt);
            if (s2_reg.data == FP_ONE) begin
                hit_cnt <= sat_inc(hit_cnt);
            end
        end
    end
`endif

endmodule

// File: tb/tb_comp_arbiter.sv
// Randomized and directed bench for comp_arbiter against a behavioural scoreboard model.
// Builds the counter checks when COMP_ARB_STATS_EN is defined.
module tb_comp_arbiter;

    localparam int          N      = 4;
    localparam logic [31:0] BIN_TB = 32'h3E800006;

    logic           clk;
    logic           rst_n;
    logic           en;
    logic [N-1:0]   req_valid;
    logic [N*32-1:0] req_data;
    logic [N-1:0]   req_ready;
    logic [N-1:0]   rsp_valid;
    logic [31:0]    rsp_data;
    logic           busy;
`ifdef COMP_ARB_STATS_EN
    logic [15:0]    hit_cnt;
    logic [15:0]    op_cnt;
`endif

    comp_arbiter #(.NUM_REQ(N), .BIN(BIN_TB)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .busy      (busy)
`ifdef COMP_ARB_STATS_EN
        ,
        .hit_cnt   (hit_cnt),
        .op_cnt    (op_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          due;
        int          id;
        logic [31:0] res;
    } exp_rsp_t;

    exp_rsp_t q[$];
    int       n_checks  = 0;
    int       n_bad     = 0;
    int       cyc       = 0;
    int       last      = N - 1;
    int       obs_grant = -1;
    int       m_ops     = 0;
    int       m_hits    = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Value-level compare: order floats as signed magnitudes; Inf/NaN never below threshold.
    function automatic logic [31:0] model_result(input logic [31:0] x);
        logic [31:0] b;
        longint kx;
        longint kb;
        b = BIN_TB;
        if (x[30:23] == 8'hFF) return 32'h0;
        kx = x[31] ? -longint'(x[30:0]) : longint'(x[30:0]);
        kb = b[31] ? -longint'(b[30:0]) : longint'(b[30:0]);
        return (kx < kb) ? 32'h3F800000 : 32'h00000000;
    endfunction

    function automatic int model_grant(input logic [N-1:0] v, input logic e);
        int c;
        if (!e) return -1;
        for (int off = 1; off <= N; off++) begin
            c = (last + off) % N;
            if (((v >> c) & 1) != 0) return c;
        end
        return -1;
    endfunction

    function automatic logic [31:0] rand_operand();
        int sel;
        sel = $urandom_range(0, 7);
        case (sel)
            0: return BIN_TB;
            1: return 32'h80000000;
            2: return 32'h00000000;
            3: return {$urandom_range(0, 1) == 1 ? 1'b1 : 1'b0, 8'hFF, 23'($urandom)};
            4: return BIN_TB + 32'($urandom_range(0, 2)) - 32'd1;
            5: return {1'b0, 8'($urandom_range(120, 130)), 23'($urandom)};
            default: return $urandom;
        endcase
    endfunction

    task automatic cycle(input logic e, input logic [N-1:0] v, input logic [N*32-1:0] d,
                         input bit verbose);
        int          g;
        logic [N-1:0] exp_ready;
        logic [N-1:0] exp_vld;
        logic [31:0]  exp_dat;
        exp_rsp_t     r;
        @(negedge clk);
        en        = e;
        req_valid = v;
        req_data  = d;
        #1;
        g         = model_grant(v, e);
        exp_ready = (g >= 0) ? N'(1 << g) : '0;
        chk("req_ready", 32'(req_ready), 32'(exp_ready));
        obs_grant = -1;
        for (int i = 0; i < N; i++) if (req_ready[i]) obs_grant = i;
        @(posedge clk);
        cyc++;
        if (g >= 0) begin
            last  = g;
            r.due = cyc + 2;
            r.id  = g;
            r.res = model_result(d[32*g +: 32]);
            q.push_back(r);
        end
        #1;
        exp_vld = '0;
        exp_dat = 32'h0;
        if (q.size() > 0 && q[0].due == cyc) begin
            r = q.pop_front();
            exp_vld = N'(1 << r.id);
            exp_dat = r.res;
            if (m_ops < 16'hFFFF) m_ops++;
            if (r.res == 32'h3F800000 && m_hits < 16'hFFFF) m_hits++;
            if (verbose)
                $display("cycle %0d: rsp id=%0d data=%h (got valid=%b data=%h)",
                         cyc, r.id, r.res, rsp_valid, rsp_data);
        end
        chk("rsp_valid", 32'(rsp_valid), 32'(exp_vld));
        chk("rsp_data", rsp_data, exp_dat);
        chk("busy", 32'(busy), 32'((q.size() > 0) || (exp_vld != 0)));
`ifdef COMP_ARB_STATS_EN
        chk("op_cnt", 32'(op_cnt), 32'(m_ops));
        chk("hit_cnt", 32'(hit_cnt), 32'(m_hits));
`endif
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n     = 1'b0;
        en        = 1'b0;
        req_valid = '0;
        #1;
        chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("rst_rsp_data", rsp_data, 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        q.delete();
        last   = N - 1;
        m_ops  = 0;
        m_hits = 0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    function automatic logic [N*32-1:0] pack4(input logic [31:0] a, input logic [31:0] b,
                                              input logic [31:0] c, input logic [31:0] d);
        return {d, c, b, a};
    endfunction

    initial begin
        logic [N*32-1:0] d;
        rst_n     = 1'b0;
        en        = 1'b0;
        req_valid = '0;
        req_data  = '0;
        #12;
        do_reset();

        // Single requester 2 sending 0.125, then idle until the response shows.
        cycle(1'b1, 4'b0100, pack4(32'h0, 32'h0, 32'h3E000000, 32'h0), 1'b1);
        cycle(1'b1, 4'b0000, '0, 1'b1);
        cycle(1'b1, 4'b0000, '0, 1'b1);
        chk("t033_rsp_valid", 32'(rsp_valid), 32'h4);
        chk("t033_rsp_data", rsp_data, 32'h3F800000);
        repeat (2) cycle(1'b1, 4'b0000, '0, 1'b1);

        // All four requesters continuously valid: strict rotation from 0.
        do_reset();
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, 4'b1111, pack4(rand_operand(), rand_operand(), rand_operand(), rand_operand()), 1'b1);
            chk("t034_grant", 32'(obs_grant), 32'(i % N));
        end
        repeat (3) cycle(1'b1, 4'b0000, '0, 1'b1);

        // Boundary operands: equal to threshold, -0, NaN.
        cycle(1'b1, 4'b0001, pack4(32'h3E800006, 32'h0, 32'h0, 32'h0), 1'b1);
        cycle(1'b1, 4'b0001, pack4(32'h80000000, 32'h0, 32'h0, 32'h0), 1'b1);
        cycle(1'b1, 4'b0001, pack4(32'h7FC00000, 32'h0, 32'h0, 32'h0), 1'b1);
        chk("t035_rsp_equal", rsp_data, 32'h0);
        cycle(1'b1, 4'b0000, '0, 1'b1);
        chk("t035_rsp_negzero", rsp_data, 32'h3F800000);
        cycle(1'b1, 4'b0000, '0, 1'b1);
        chk("t035_rsp_nan", rsp_data, 32'h0);
        cycle(1'b1, 4'b0000, '0, 1'b1);

        // Enable dropped right after a transfer: no grants, pipeline drains.
        cycle(1'b1, 4'b0010, pack4(32'h0, 32'h3D000000, 32'h0, 32'h0), 1'b1);
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, 4'b1111, pack4(32'h0, 32'h0, 32'h0, 32'h0), 1'b1);
            chk("t036_ready_low", 32'(req_ready), 32'h0);
        end
        chk("t036_busy_drained", 32'(busy), 32'h0);

        // Reset with S1/S2 full: in-flight operands vanish, pointer restarts at 0.
        cycle(1'b1, 4'b1111, pack4(32'h0, 32'h0, 32'h0, 32'h0), 1'b1);
        cycle(1'b1, 4'b1111, pack4(32'h0, 32'h0, 32'h0, 32'h0), 1'b1);
        do_reset();
        cycle(1'b1, 4'b1111, pack4(32'h3F800000, 32'h0, 32'h0, 32'h0), 1'b1);
        chk("t037_first_grant", 32'(obs_grant), 32'h0);
        chk("t037_no_rsp", 32'(rsp_valid), 32'h0);
        repeat (3) cycle(1'b0, 4'b0000, '0, 1'b1);

        // Randomized traffic.
        for (int i = 0; i < 300; i++) begin
            d = pack4(rand_operand(), rand_operand(), rand_operand(), rand_operand());
            cycle(($urandom_range(0, 9) < 8) ? 1'b1 : 1'b0, N'($urandom), d, 1'b1);
        end
        repeat (3) cycle(1'b1, 4'b0000, '0, 1'b1);

`ifdef COMP_ARB_STATS_EN
        // Drive enough responses to saturate the operation counter.
        do_reset();
        for (int i = 0; i < 70000; i++) begin
            cycle(1'b1, 4'b1111, pack4(rand_operand(), rand_operand(), rand_operand(), rand_operand()), 1'b0);
        end
        repeat (3) cycle(1'b1, 4'b0000, '0, 1'b0);
        chk("t038_op_cnt_sat", 32'(op_cnt), 32'h0000FFFF);
`endif

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
